// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the instruction-fetch port (I) and the data port (D)
// share one single-ported memory. Only one transaction is in flight at a time.
// D has priority over I, and a starvation guard lets a waiting I through.
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   I_*         fetch port: REQ/ADDR in; GNT, RVALID, RDATA out
//   D_*         data port: REQ/RW/ADDR/WDATA in; GNT, DONE, RDATA out
//   M_*         memory port: REQ/RW/ADDR/WDATA out; RDATA in
module mem_port_arbiter #(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_GNT,
    output logic          I_RVALID,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_RW,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_DONE,
    output logic [DW-1:0] D_RDATA,
    output logic          M_REQ,
    output logic          M_RW,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic [DW-1:0] M_RDATA
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(MEM_LAT + 1);

    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [LW-1:0] LAT_LOAD   = LW'(MEM_LAT);
    localparam logic [LW-1:0] LAT_LAST   = LW'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RETURN = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] wait_q, wait_d;
    // Owner of the in-flight access: 1 = D port, 0 = I port.
    logic          src_d_q, src_d_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic arb_ok;
    logic d_win;
    logic i_win;
    logic capture;

    // RETURN arbitrates like IDLE so reads can run back-to-back.
    // I overrides D only once D has been granted STARVE_MAX times in a row
    // while I was waiting.
    always_comb begin
        arb_ok = !RST && ((state_q == ST_IDLE) || (state_q == ST_RETURN));
        d_win  = arb_ok && D_REQ && !(I_REQ && (starve_q == STARVE_TOP));
        i_win  = arb_ok && I_REQ && !d_win;
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        wait_d    = wait_q;
        src_d_d   = src_d_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        capture   = (state_q == ST_WAIT) && (wait_q == LAT_LAST);

        unique case (state_q)
            ST_IDLE, ST_RETURN: begin
                state_d = ST_IDLE;
                if (d_win || i_win) begin
                    state_d = ST_ISSUE;
                    src_d_d = d_win;
                    rw_d    = d_win && D_RW;
                    addr_d  = d_win ? D_ADDR : I_ADDR;
                    wdata_d = d_win ? D_WDATA : '0;
                    if (d_win && I_REQ) begin
                        if (starve_q != STARVE_TOP) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                wait_d  = LAT_LOAD;
                state_d = rw_q ? ST_RETURN : ST_WAIT;
            end
            ST_WAIT: begin
                if (capture) begin
                    state_d = ST_RETURN;
                    if (src_d_q) begin
                        d_rdata_d = M_RDATA;
                    end else begin
                        i_rdata_d = M_RDATA;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            starve_q  <= '0;
            wait_q    <= '0;
            src_d_q   <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wait_q    <= wait_d;
            src_d_q   <= src_d_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // The command registers are exposed only in ISSUE so the memory bus
    // reads as all-zero whenever no strobe is present.
    always_comb begin
        I_GNT    = i_win;
        D_GNT    = d_win;
        I_RVALID = (state_q == ST_RETURN) && !src_d_q;
        D_DONE   = (state_q == ST_RETURN) && src_d_q;
        I_RDATA  = i_rdata_q;
        D_RDATA  = d_rdata_q;
        M_REQ    = (state_q == ST_ISSUE);
        M_RW     = M_REQ && rw_q;
        M_ADDR   = M_REQ ? addr_q : '0;
        M_WDATA  = M_REQ ? wdata_q : '0;
    end
endmodule
